// File: rtl/banco_registradores_tag_if.sv
// banco_registradores_tag_if: read, issue, CDB and status bundle for the tagged register file
interface banco_registradores_tag_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int TAGW  = 3
);
  localparam int AW = $clog2(NREGS);
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic [TAGW-1:0]  rd_tag_a;
  logic [TAGW-1:0]  rd_tag_b;
  logic             iss_valid;
  logic [AW-1:0]    iss_addr;
  logic [TAGW-1:0]  iss_tag;
  logic             cdb_valid;
  logic [TAGW-1:0]  cdb_tag;
  logic [WIDTH-1:0] cdb_data;
  logic             flush;
  logic [AW:0]      busy_count;
  modport master (
    output rd_addr_a, rd_addr_b, iss_valid, iss_addr, iss_tag,
           cdb_valid, cdb_tag, cdb_data, flush,
    input  rd_data_a, rd_data_b, rd_tag_a, rd_tag_b, busy_count
  );
  modport slave (
    input  rd_addr_a, rd_addr_b, iss_valid, iss_addr, iss_tag,
           cdb_valid, cdb_tag, cdb_data, flush,
    output rd_data_a, rd_data_b, rd_tag_a, rd_tag_b, busy_count
  );
endinterface

// File: rtl/banco_registradores_tag.sv
// banco_registradores_tag: register file with Tomasulo-style producer tags and CDB bypass
module banco_registradores_tag #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int TAGW  = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  banco_registradores_tag_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [WIDTH-1:0] v   [NREGS];
  logic [WIDTH-1:0] v_n [NREGS];
  logic [TAGW-1:0]  q   [NREGS];
  logic [TAGW-1:0]  q_n [NREGS];
  logic [AW:0]      cnt;
  logic [AW:0]      busy;
  logic             cdb_hit;
  logic             hit_a;
  logic             hit_b;
  assign cdb_hit = bus.cdb_valid && bus.cdb_tag != '0;
  // entry 0 is pinned to zero so the read path needs no special case
  always_comb begin
    cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      v_n[r] = v[r];
      q_n[r] = q[r];
      if (r == 0) begin
        v_n[r] = '0;
        q_n[r] = '0;
      end else if (bus.flush) q_n[r] = '0;
      else if (bus.iss_valid && bus.iss_addr == AW'(r)) q_n[r] = bus.iss_tag;
      else if (cdb_hit && q[r] == bus.cdb_tag) begin
        v_n[r] = bus.cdb_data;
        q_n[r] = '0;
      end
      cnt = cnt + (AW+1)'(q_n[r] != '0);
    end
  end
  always_comb begin
    hit_a = cdb_hit && q[bus.rd_addr_a] == bus.cdb_tag;
    hit_b = cdb_hit && q[bus.rd_addr_b] == bus.cdb_tag;
    bus.rd_data_a = hit_a ? bus.cdb_data : v[bus.rd_addr_a];
    bus.rd_data_b = hit_b ? bus.cdb_data : v[bus.rd_addr_b];
    bus.rd_tag_a  = hit_a ? '0 : q[bus.rd_addr_a];
    bus.rd_tag_b  = hit_b ? '0 : q[bus.rd_addr_b];
  end
  assign bus.busy_count = busy;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        v[r] <= '0;
        q[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        v[r] <= v_n[r];
        q[r] <= q_n[r];
      end
      busy <= cnt;
    end
  end
endmodule

// File: tb/tb_banco_registradores_tag.sv
// tb_banco_registradores_tag: directed and randomized checks against a behavioural register-file model
module tb_banco_registradores_tag;
  localparam int W = 16;
  localparam int N = 8;
  localparam int T = 3;
  localparam int A = 3;
  logic clock = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mv [N];
  logic [T-1:0] mq [N];
  banco_registradores_tag_if #(.WIDTH(W), .NREGS(N), .TAGW(T)) bus ();
  banco_registradores_tag #(.WIDTH(W), .NREGS(N), .TAGW(T)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;

  function automatic logic byp(int a);
    return bus.cdb_valid && bus.cdb_tag != 0 && mq[a] == bus.cdb_tag;
  endfunction
  function automatic logic [W+T-1:0] port_exp(int a);
    return byp(a) ? {bus.cdb_data, T'(0)} : {mv[a], mq[a]};
  endfunction
  function automatic logic [A:0] busy_exp();
    int c = 0;
    for (int r = 0; r < N; r++) c += (mq[r] != 0) ? 1 : 0;
    return (A+1)'(c);
  endfunction

  task automatic idle();
    bus.iss_valid = 0; bus.iss_addr = 0; bus.iss_tag = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    bus.flush = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
  endtask
  task automatic model_clear();
    for (int r = 0; r < N; r++) begin mv[r] = 0; mq[r] = 0; end
  endtask
  // advance the model by the architectural rules, then the DUT by one edge
  task automatic tick();
    if (bus.flush) for (int r = 0; r < N; r++) mq[r] = 0;
    else begin
      for (int r = 1; r < N; r++)
        if (!(bus.iss_valid && int'(bus.iss_addr) == r) && bus.cdb_valid && bus.cdb_tag != 0 && mq[r] == bus.cdb_tag) begin
          mv[r] = bus.cdb_data;
          mq[r] = 0;
        end
      if (bus.iss_valid && bus.iss_addr != 0) mq[bus.iss_addr] = bus.iss_tag;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clock);
    reset = 1; #1;
    model_clear();
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_a = A'(i); bus.rd_addr_b = A'(N-1-i); #1;
      checks++;
      if ({bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b, bus.busy_count} !== '0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h want=0", i, {bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b, bus.busy_count});
      end
    end
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_rename_cdb();
    idle(); bus.iss_valid = 1; bus.iss_addr = 3; bus.iss_tag = 5; tick();
    idle(); bus.rd_addr_a = 3; #1;
    checks++;
    if ({bus.rd_tag_a, bus.busy_count} !== {3'd5, 4'd1}) begin
      errors++; $display("FAIL rename tag/busy got=%h want=%h", {bus.rd_tag_a, bus.busy_count}, {3'd5, 4'd1});
    end
    bus.cdb_valid = 1; bus.cdb_tag = 5; bus.cdb_data = 16'h00AB; #1;
    checks++;
    if ({bus.rd_data_a, bus.rd_tag_a} !== {16'h00AB, 3'd0}) begin
      errors++; $display("FAIL bypass got=%h want=%h", {bus.rd_data_a, bus.rd_tag_a}, {16'h00AB, 3'd0});
    end
    tick(); idle(); bus.rd_addr_a = 3; #1;
    checks++;
    if ({bus.rd_data_a, bus.rd_tag_a, bus.busy_count} !== {16'h00AB, 3'd0, 4'd0}) begin
      errors++; $display("FAIL cdb_writeback got=%h want=%h", {bus.rd_data_a, bus.rd_tag_a, bus.busy_count}, {16'h00AB, 3'd0, 4'd0});
    end
  endtask

  task automatic test_multi_match();
    idle(); bus.iss_valid = 1; bus.iss_addr = 2; bus.iss_tag = 6; tick();
    bus.iss_addr = 4; tick();
    idle(); bus.cdb_valid = 1; bus.cdb_tag = 6; bus.cdb_data = 7; tick();
    idle(); bus.rd_addr_a = 2; bus.rd_addr_b = 4; #1;
    checks++;
    if ({bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b} !== {16'd7, 3'd0, 16'd7, 3'd0}) begin
      errors++; $display("FAIL multi_match got=%h want=%h", {bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b}, {16'd7, 3'd0, 16'd7, 3'd0});
    end
  endtask

  task automatic test_issue_wins();
    idle(); bus.iss_valid = 1; bus.iss_addr = 1; bus.iss_tag = 2; tick();
    bus.iss_tag = 4; bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_data = 9; tick();
    idle(); bus.rd_addr_a = 1; #1;
    checks++;
    if ({bus.rd_data_a, bus.rd_tag_a} !== {16'd0, 3'd4}) begin
      errors++; $display("FAIL issue_wins got=%h want=%h", {bus.rd_data_a, bus.rd_tag_a}, {16'd0, 3'd4});
    end
  endtask

  task automatic test_reg0();
    logic [A:0] b0;
    b0 = busy_exp();
    idle(); bus.iss_valid = 1; bus.iss_addr = 0; bus.iss_tag = 3;
    bus.cdb_valid = 1; bus.cdb_tag = 0; bus.cdb_data = 5; #1;
    checks++;
    if ({bus.rd_data_a, bus.rd_tag_a} !== '0) begin
      errors++; $display("FAIL reg0_read got=%h want=0", {bus.rd_data_a, bus.rd_tag_a});
    end
    tick(); idle();
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_a = A'(i); #1;
      checks++;
      if ({bus.rd_data_a, bus.rd_tag_a, bus.busy_count} !== {port_exp(i), b0}) begin
        errors++; $display("FAIL reg0_nochange addr=%0d got=%h want=%h", i, {bus.rd_data_a, bus.rd_tag_a, bus.busy_count}, {port_exp(i), b0});
      end
    end
  endtask

  task automatic test_flush_reset();
    idle(); bus.iss_valid = 1; bus.iss_addr = 2; bus.iss_tag = 5; tick();
    bus.iss_addr = 6; bus.iss_tag = 7; tick();
    idle(); #1;
    checks++;
    if (bus.busy_count !== 4'd3) begin
      errors++; $display("FAIL busy3 got=%0d want=3", bus.busy_count);
    end
    bus.flush = 1; bus.iss_valid = 1; bus.iss_addr = 5; bus.iss_tag = 1;
    bus.cdb_valid = 1; bus.cdb_tag = 4; bus.cdb_data = 16'hFFFF; tick();
    idle();
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_a = A'(i); #1;
      checks++;
      if ({bus.rd_data_a, bus.rd_tag_a, bus.busy_count} !== {mv[i], 3'd0, 4'd0}) begin
        errors++; $display("FAIL flush addr=%0d got=%h want=%h", i, {bus.rd_data_a, bus.rd_tag_a, bus.busy_count}, {mv[i], 3'd0, 4'd0});
      end
    end
    bus.iss_valid = 1; bus.iss_addr = 3; bus.iss_tag = 2; tick();
    idle(); bus.rd_addr_a = 3; bus.rd_addr_b = 2; #2;
    reset = 1; #1;
    model_clear();
    checks++;
    if ({bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b, bus.busy_count} !== '0) begin
      errors++; $display("FAIL async_reset got=%h want=0", {bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b, bus.busy_count});
    end
    @(negedge clock); reset = 0;
    bus.iss_valid = 1; bus.iss_addr = 1; bus.iss_tag = 3; tick();
    idle(); bus.rd_addr_a = 1; #1;
    checks++;
    if ({bus.rd_tag_a, bus.busy_count} !== {3'd3, 4'd1}) begin
      errors++; $display("FAIL post_reset got=%h want=%h", {bus.rd_tag_a, bus.busy_count}, {3'd3, 4'd1});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.iss_valid = 1'($urandom_range(1));
      bus.iss_addr  = A'($urandom_range(N-1));
      bus.iss_tag   = T'($urandom_range(7));
      bus.cdb_valid = 1'($urandom_range(1));
      bus.cdb_tag   = $urandom_range(1) ? mq[$urandom_range(N-1)] : T'($urandom_range(7));
      bus.cdb_data  = W'($urandom);
      bus.flush     = ($urandom_range(15) == 0);
      bus.rd_addr_a = A'($urandom_range(N-1));
      bus.rd_addr_b = A'($urandom_range(N-1));
      #1;
      checks++;
      if ({bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b} !== {port_exp(bus.rd_addr_a), port_exp(bus.rd_addr_b)}) begin
        errors++; $display("FAIL rand_read n=%0d got=%h want=%h", n, {bus.rd_data_a, bus.rd_tag_a, bus.rd_data_b, bus.rd_tag_b}, {port_exp(bus.rd_addr_a), port_exp(bus.rd_addr_b)});
      end
      tick();
      checks++;
      if (bus.busy_count !== busy_exp()) begin
        errors++; $display("FAIL rand_busy n=%0d got=%0d want=%0d", n, bus.busy_count, busy_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rename_cdb();
    test_multi_match();
    test_issue_wins();
    test_reg0();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/banco_registradores_tag.md
BANCO_REGISTRADORES_TAG -- requirements
Module: banco_registradores_tag

Interface
REQ-001 The block SHALL accept parameter WIDTH, default 16, as the data width of each register.
REQ-002 The block SHALL accept parameter NREGS, default 8, as the number of architectural registers (power of two, minimum 4).
REQ-003 The block SHALL accept parameter TAGW, default 3, as the reservation-station tag width; tag value 0 SHALL be reserved as "no producer".
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports rd_addr_a and rd_addr_b, input, log2(NREGS) bits each: read port addresses.
REQ-007 The block SHALL have ports rd_data_a and rd_data_b, output, WIDTH bits each: operand value per port.
REQ-008 The block SHALL have ports rd_tag_a and rd_tag_b, output, TAGW bits each: pending producer tag per port, 0 when ready.
REQ-009 The block SHALL have ports iss_valid (input, 1 bit), iss_addr (input, log2(NREGS) bits) and iss_tag (input, TAGW bits): issue rename of a destination register.
REQ-010 The block SHALL have ports cdb_valid (input, 1 bit), cdb_tag (input, TAGW bits) and cdb_data (input, WIDTH bits): common data bus broadcast.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous clear of all pending tags.
REQ-012 The block SHALL have port busy_count, output, log2(NREGS)+1 bits: registered count of registers with non-zero tag.

Function
REQ-013 Register 0 SHALL always read value 0 with tag 0; issue and CDB updates to index 0 SHALL be ignored.
REQ-014 Each register r in 1..NREGS-1 SHALL hold value V[r] (WIDTH bits) and tag Q[r] (TAGW bits).
REQ-015 Reads SHALL be combinational: rd_data = V[addr] and rd_tag = Q[addr].
REQ-016 CDB bypass: if cdb_valid, cdb_tag != 0 and Q[addr] == cdb_tag, the read port SHALL return rd_data = cdb_data and rd_tag = 0 in the same cycle.
REQ-017 On each edge with cdb_valid and cdb_tag != 0, every register r with Q[r] == cdb_tag SHALL load V[r] = cdb_data and Q[r] = 0; multiple registers MAY match simultaneously.
REQ-018 On each edge with iss_valid and iss_addr != 0, Q[iss_addr] SHALL load iss_tag; iss_tag = 0 SHALL mark the register ready without changing V.
REQ-019 Simultaneous issue and CDB on the same register: issue SHALL win; Q takes iss_tag and V SHALL be left unchanged.
REQ-020 cdb_valid with cdb_tag = 0 SHALL be ignored.
REQ-021 flush SHALL set every Q[r] to 0 and leave V unchanged; flush SHALL take priority over issue and CDB in the same cycle, which are then discarded.
REQ-022 busy_count SHALL equal the number of non-zero Q[r] after the edge, saturating naturally at NREGS-1.
REQ-023 Values SHALL be stored unmodified; no arithmetic on data.

Reset
REQ-024 While reset is high, every V[r] and Q[r] SHALL be 0 and busy_count SHALL be 0, independent of clock.
REQ-025 Reset asserted mid-operation SHALL discard pending tags immediately; the first edge after deassertion SHALL process inputs normally.

Verification
REQ-026 Reset with all inputs idle, then read all addresses -> all rd_data = 0, all rd_tag = 0, busy_count = 0.
REQ-027 Issue reg 3 with tag 5, then CDB tag 5 data 16'h00AB -> Q[3] = 5 and busy_count = 1 after the first edge; during the CDB cycle, read of 3 bypasses to 16'h00AB with tag 0; after the edge V[3] = 16'h00AB and busy_count = 0.
REQ-028 Issue regs 2 and 4 with tag 6 on consecutive cycles, then CDB tag 6 data 7 -> both V = 7, both tags 0.
REQ-029 With Q[1] = 2, issue reg 1 with tag 4 and CDB tag 2 data 9 in the same cycle -> Q[1] = 4 and V[1] unchanged.
REQ-030 Issue to reg 0 with tag 3, and CDB tag 0 data 5 -> no state change; reg 0 reads 0 with tag 0.
REQ-031 With three busy registers, flush together with an issue to reg 5 -> all tags 0, busy_count = 0, and V unchanged; then assert reset between edges -> all outputs 0 immediately.
